neuron_sweep_scheduler: RTL

// - Per-tick sequencer for a core's neuron datapath. Each tick it walks a neuron index through 0..NUM_NEURONS-1.
// - Issues one index per valid/ready handshake to the neuron-update unit, then pulses done.
// - Owns the core's neuron index counter. The index register resets to all-ones, so the first advance wraps it to 0.
//

---
 rtl/neuron_sweep_scheduler_if.sv | 24 ++
 rtl/neuron_sweep_scheduler.sv | 105 ++++++++++
 2 files changed

// File: rtl/neuron_sweep_scheduler_if.sv
// Neuron index handshake between the sweep scheduler (master) and the neuron-update unit (slave).
// Carries index, valid, last-flag and ready; width follows NEURON_WIDTH.
interface neuron_sweep_scheduler_if #(
    parameter int NEURON_WIDTH = 8
);
    logic [NEURON_WIDTH-1:0] neuron_idx;
    logic                    neuron_valid;
    logic                    neuron_ready;
    logic                    last;

    modport master (
        output neuron_idx,
        output neuron_valid,
        output last,
        input  neuron_ready
    );

    modport slave (
        input  neuron_idx,
        input  neuron_valid,
        input  last,
        output neuron_ready
    );
endinterface

// File: rtl/neuron_sweep_scheduler.sv
// Per-tick neuron index sweeper: issues 0..NUM_NEURONS-1 over valid/ready, then pulses done.
// Latency: tick sampled on a falling edge -> idx 0 valid after that edge; one index per cycle at full ready.
// Backpressure: idx/valid hold while !ready; NEURON_SWEEP_TICK_OVERRUN_EN adds a 1-deep tick queue + overrun flag.
module neuron_sweep_scheduler #(
    parameter int NUM_NEURONS  = 256,
    parameter int NEURON_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    output logic                     busy,
    output logic                     done,
    output logic                     tick_overrun,
    neuron_sweep_scheduler_if.master nif
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [NEURON_WIDTH-1:0] LAST_IDX = NEURON_WIDTH'(NUM_NEURONS - 1);
    localparam logic [NEURON_WIDTH-1:0] ONE      = NEURON_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [NEURON_WIDTH-1:0] idx_q, idx_d;
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
    logic pend_q, pend_d;
    logic ovr_q, ovr_d;
`endif

    // State lives on the falling edge so the datapath can sample on the rising edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '1;
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
        pend_d  = pend_q;
        ovr_d   = ovr_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ISSUE;
                    idx_d   = idx_q + ONE;
                end
            end
            ISSUE: begin
                if (nif.neuron_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '1;
                    end else begin
                        idx_d   = idx_q + ONE;
                    end
                end
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
                if (tick) begin
                    if (pend_q) ovr_d  = 1'b1;
                    else        pend_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
                // A tick landing in DONE is queued and consumed in the same cycle.
                if (pend_q || tick) begin
                    state_d = ISSUE;
                    idx_d   = idx_q + ONE;
                end
                pend_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                idx_d   = '1;
            end
        endcase
    end

    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign nif.neuron_valid = (state_q == ISSUE);
    assign nif.neuron_idx   = idx_q;
    assign nif.last         = (state_q == ISSUE) && (idx_q == LAST_IDX);
`ifdef NEURON_SWEEP_TICK_OVERRUN_EN
    assign tick_overrun     = ovr_q;
`else
    assign tick_overrun     = 1'b0;
`endif
endmodule
